vga_vram_arbiter: RTL and testbench
===================================

# vga_vram_arbiter

Single-port text-VRAM arbiter for the 640x480 text display. It shares one synchronous-read 2400x8 character RAM (80x30 cells, 8x16 glyphs) between the pixel pipeline and a host port (mouse/CPU writer). Video fetches get absolute priority, timed from the sync generator's pixel_x/pixel_y/p_tick. Host commands are buffered in a 4-entry FIFO and served in free cycles.

## Interface
- DEPTH, 4: host command FIFO depth (power of 2).
- COLS, 80: text columns; ROWS, 30: text rows; VRAM_SIZE = COLS*ROWS = 2400.
- clk  in  1  system clock (50 MHz; pixel rate is clk/2).
- rst  in  1  asynchronous, active-high reset.
- p_tick  in  1  pixel-enable strobe from the sync generator, high every other clk.
- video_on  in  1  active-display flag.
- pixel_x, pixel_y  in  10 each  current pixel coordinates.
- host_valid  in  1  host command present; host_ready  out  1  FIFO can accept.
- host_we  in  1  1 = write, 0 = read; host_addr  in  12; host_wdata  in  8.
- host_rvalid  out  1  one-cycle read-data strobe; host_rdata  out  8.
- ram_addr  out  12; ram_we  out  1; ram_wdata  out  8; ram_rdata  in  8 (valid 1 clk after address).
- char_code  out  8  character for the current cell; char_valid  out  1  one-cycle update strobe.
- addr_err  out  1  sticky; set when a host command with host_addr >= 2400 is popped.

## Operation
- Video slot: cycle with p_tick=1, video_on=1, pixel_x[2:0]=0. ram_addr = pixel_y[8:4]*80 + pixel_x[9:3], computed as (row<<6)+(row<<4)+col in 12 bits (max 2399). ram_we=0.
- Host slot: any non-video-slot cycle with the FIFO non-empty. The FIFO head is popped and driven to the RAM.
  - Write: ram_we=1 for one clk.
  - Read: ram_we=0.
- Out-of-range host_addr (>=2400):
  - The command is popped but not driven to the RAM (ram_we stays 0).
  - A read still returns host_rdata=8'h00 with host_rvalid, at normal latency.
  - addr_err is set.
- Idle cycles: ram_we=0; ram_addr holds its last value.
- Read-return routing register: owner of previous cycle = {NONE, VID, HOST}.
  - VID: char_code <= ram_rdata, char_valid=1.
  - HOST: host_rdata <= ram_rdata, host_rvalid=1.
- FIFO push: host_valid & host_ready. host_ready = !full (registered count).
  - Simultaneous push and pop is legal at any non-full occupancy.
  - Push while full cannot happen (ready low).
- Commands complete in FIFO order. A host write followed by a read of the same address returns the new data.
- Reset values:
  - All outputs 0: ram_addr=0, ram_we=0, ram_wdata=0, host_rvalid=0, host_rdata=0, char_code=0, char_valid=0, addr_err=0.
  - host_ready=1; FIFO empty; owner=NONE.
- Reset mid-operation discards FIFO contents, and no pending host_rvalid is issued after reset release.

## Timing
- Video: address in cycle T (slot); ram_rdata in T+1; char_code/char_valid visible from T+2. This is 2 clk = 1 pixel, so the renderer delays pixel data by 1 pixel.
- Host read: popped in cycle P; host_rvalid=1 and host_rdata valid in cycle P+2, for exactly one clk.
- Host write: RAM written at the clk edge ending cycle P.
- Minimum push-to-pop latency: 1 clk (pushed at edge E, earliest pop in cycle after E).
- Host throughput:
  - Outside the active display: 1 command/clk.
  - During the active display: 15 of every 16 clks.
- A video slot pre-empts a host pop only in that cycle. The head is held, not dropped.

## Configuration
- VRAM_BLANK_ONLY_EN defined: host slots are allowed only when video_on=0 (tear-free updates).
  - During the active display the FIFO only fills; host_ready drops when full.
- VRAM_BLANK_ONLY_EN undefined: host slots are allowed in any non-video-slot cycle, as described above.

## Test plan
- Reset: assert rst mid-stream with 3 commands queued -> all outputs 0, host_ready=1, no host_rvalid after release, FIFO empty.
- Video fetch: pixel_y=37, pixel_x=200, p_tick=1, video_on=1 -> ram_addr=2*80+25=185, ram_we=0; ram_rdata=8'h41 next clk -> char_code=8'h41 with char_valid 2 clk after the slot.
- Priority collision: host write (addr 10, data 8'h5A) queued in the same cycle as a video slot -> video address driven first, write performed the next clk, no loss; subsequent read of 10 returns 8'h5A at pop+2.
- FIFO full: push 4 commands with video_on=1 and VRAM_BLANK_ONLY_EN defined -> host_ready=0 after the 4th push; video_on=0 -> 4 pops on consecutive clks, host_ready returns 1.
- Out of range: host read at addr 2400 -> ram_we=0, host_rvalid with host_rdata=8'h00 at pop+2, addr_err=1 and stays set.
- Full-frame sweep: 800x525 pixel counters running with random host traffic -> every video slot fetches the correct row*80+col, and host read data matches a reference model.

Source files
------------

// File: rtl/vga_vram_arbiter.sv
// Single-port text-VRAM arbiter: video fetches take priority, host commands queue in a FIFO.
// Define VRAM_BLANK_ONLY_EN to allow host access only while video_on is low.
module vga_vram_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned COLS  = 80,
    parameter int unsigned ROWS  = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic        host_we,
    input  logic [11:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_rvalid,
    output logic [7:0]  host_rdata,
    output logic [11:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  char_code,
    output logic        char_valid,
    output logic        addr_err
);
    localparam int unsigned VRAM_SIZE = COLS * ROWS;
    localparam int unsigned PW        = $clog2(DEPTH);
    localparam int unsigned EW        = 21;
    localparam logic [1:0]  OWN_NONE  = 2'd0;
    localparam logic [1:0]  OWN_VID   = 2'd1;
    localparam logic [1:0]  OWN_HOST  = 2'd2;

    logic [EW-1:0] fifo_q [DEPTH];
    logic [EW-1:0] fifo_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [11:0]   ram_addr_q, ram_addr_d;
    logic [7:0]    ram_wdata_q, ram_wdata_d;
    logic [1:0]    owner_q, owner_d;
    logic          zero_q, zero_d;
    logic          err_q, err_d;
    logic [7:0]    char_code_q, char_code_d;
    logic          char_valid_q, char_valid_d;
    logic [7:0]    host_rdata_q, host_rdata_d;
    logic          host_rvalid_q, host_rvalid_d;

    logic          video_slot, host_ok, push, pop, head_we, in_range;
    logic [11:0]   head_addr, vid_addr;
    logic [7:0]    head_wdata;
    logic [4:0]    vid_row;
    logic [6:0]    vid_col;
    logic          unused_pixel_bits;

    assign unused_pixel_bits = ^{pixel_y[9], pixel_y[3:0]};

    assign vid_row  = pixel_y[8:4];
    assign vid_col  = pixel_x[9:3];
    // row*80 as two shifts keeps the multiplier out of the fetch path
    assign vid_addr = ({7'd0, vid_row} << 6) + ({7'd0, vid_row} << 4) + {5'd0, vid_col};

    assign video_slot = !rst && p_tick && video_on && (pixel_x[2:0] == 3'd0);
`ifdef VRAM_BLANK_ONLY_EN
    assign host_ok = !video_on;
`else
    assign host_ok = !video_slot;
`endif

    assign host_ready = (count_q != (PW+1)'(DEPTH));
    assign push       = host_valid && host_ready;
    assign pop        = host_ok && (count_q != '0);

    assign {head_we, head_addr, head_wdata} = fifo_q[rd_ptr_q];
    assign in_range = (head_addr < 12'(VRAM_SIZE));

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {host_we, host_addr, host_wdata};
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we      = 1'b0;
        owner_d     = OWN_NONE;
        zero_d      = 1'b0;
        err_d       = err_q;
        if (video_slot) begin
            ram_addr_d = vid_addr;
            owner_d    = OWN_VID;
        end else if (pop) begin
            if (in_range) begin
                ram_addr_d = head_addr;
                ram_we     = head_we;
                if (head_we) begin
                    ram_wdata_d = head_wdata;
                end
            end else begin
                err_d = 1'b1;
            end
            // Out-of-range reads still complete, returning zero at normal latency
            if (!head_we) begin
                owner_d = OWN_HOST;
                zero_d  = !in_range;
            end
        end
    end

    assign ram_addr  = ram_addr_d;
    assign ram_wdata = ram_wdata_d;

    always_comb begin
        char_code_d   = char_code_q;
        char_valid_d  = (owner_q == OWN_VID);
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = (owner_q == OWN_HOST);
        if (owner_q == OWN_VID) begin
            char_code_d = ram_rdata;
        end
        if (owner_q == OWN_HOST) begin
            host_rdata_d = zero_q ? 8'h00 : ram_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            owner_q       <= OWN_NONE;
            zero_q        <= 1'b0;
            err_q         <= 1'b0;
            char_code_q   <= '0;
            char_valid_q  <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            owner_q       <= owner_d;
            zero_q        <= zero_d;
            err_q         <= err_d;
            char_code_q   <= char_code_d;
            char_valid_q  <= char_valid_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign char_code   = char_code_q;
    assign char_valid  = char_valid_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign addr_err    = err_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: directed steps plus a pixel-counter sweep, with a VRAM model
// and scoreboards for host read data and video character fetches.
module tb_vga_vram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, p_tick, video_on, host_valid, host_ready, host_we, host_rvalid;
    logic [9:0]  pixel_x, pixel_y;
    logic [11:0] host_addr, ram_addr;
    logic [7:0]  host_wdata, host_rdata, ram_wdata, ram_rdata, char_code;
    logic        ram_we, char_valid, addr_err;

    vga_vram_arbiter dut (
        .clk(clk), .rst(rst), .p_tick(p_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .host_valid(host_valid),
        .host_ready(host_ready), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .char_code(char_code), .char_valid(char_valid), .addr_err(addr_err)
    );

    typedef struct {
        int         due;
        logic [7:0] d;
    } vexp_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [7:0]  mem    [4096];
    logic [7:0]  shadow [4096];
    logic [7:0]  hq [$];
    vexp_t       vq [$];
    logic        we_s = 1'b0;
    logic [11:0] a_s = '0;
    logic [7:0]  wd_s = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Synchronous-read VRAM; port values are captured mid-cycle to avoid edge races
    always @(posedge clk) begin
        if (we_s) mem[a_s] <= wd_s;
        ram_rdata <= mem[a_s];
    end

    always @(negedge clk) begin
        int    exp_a;
        vexp_t e;
        cyc++;
        we_s = ram_we;
        a_s  = ram_addr;
        wd_s = ram_wdata;
        if (rst) begin
            hq.delete();
            vq.delete();
        end else begin
            if (host_valid && host_ready) begin
                if (host_we) begin
                    if (host_addr < 12'd2400) shadow[host_addr] = host_wdata;
                end else begin
                    hq.push_back((host_addr < 12'd2400) ? shadow[host_addr] : 8'h00);
                end
            end
            if (p_tick && video_on && pixel_x[2:0] == 3'd0) begin
                exp_a = int'(pixel_y[8:4]) * 80 + int'(pixel_x[9:3]);
                chk("vid_addr", {20'd0, ram_addr}, exp_a);
                chk("vid_we", {31'd0, ram_we}, 0);
                e.due = cyc + 2;
                e.d   = mem[exp_a];
                vq.push_back(e);
            end
            if (vq.size() > 0 && vq[0].due == cyc) begin
                chk("char_valid", {31'd0, char_valid}, 1);
                chk("char_code", {24'd0, char_code}, {24'd0, vq[0].d});
                void'(vq.pop_front());
            end else begin
                chk("char_valid_idle", {31'd0, char_valid}, 0);
            end
            if (host_rvalid) begin
                chk("rvalid_expected", (hq.size() > 0) ? 1 : 0, 1);
                if (hq.size() > 0) begin
                    chk("host_rdata", {24'd0, host_rdata}, {24'd0, hq[0]});
                    void'(hq.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_tick = 1'b0; video_on = 1'b0; pixel_x = 10'd1; pixel_y = 10'd0;
        host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic slot(input logic [9:0] x, input logic [9:0] y);
        p_tick = 1'b1; video_on = 1'b1; pixel_x = x; pixel_y = y;
    endtask

    task automatic cmd(input logic we, input logic [11:0] a, input logic [7:0] d);
        host_valid = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ram_addr", {20'd0, ram_addr}, 0);
        chk("rst_ram_we", {31'd0, ram_we}, 0);
        chk("rst_ram_wdata", {24'd0, ram_wdata}, 0);
        chk("rst_host_rvalid", {31'd0, host_rvalid}, 0);
        chk("rst_host_rdata", {24'd0, host_rdata}, 0);
        chk("rst_char_code", {24'd0, char_code}, 0);
        chk("rst_char_valid", {31'd0, char_valid}, 0);
        chk("rst_addr_err", {31'd0, addr_err}, 0);
        chk("rst_host_ready", {31'd0, host_ready}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int x, y;
        logic ph;
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 8'(i * 37 + 11);
            shadow[i] = mem[i];
        end
        mem[185] = 8'h41;
        shadow[185] = 8'h41;
        rst = 1'b1;
        idle();
        repeat (3) step();
        @(negedge clk);
        chk_reset_outputs();
        step(); rst = 1'b0;
        step(); step();

        // Video fetch: row 2, column 25
        slot(10'd200, 10'd37);
        @(negedge clk);
        chk("fetch_addr", {20'd0, ram_addr}, 185);
        chk("fetch_we", {31'd0, ram_we}, 0);
        step(); p_tick = 1'b0; pixel_x = 10'd201;
        @(negedge clk);
        chk("fetch_valid_t1", {31'd0, char_valid}, 0);
        step(); p_tick = 1'b1;
        @(negedge clk);
        chk("fetch_valid_t2", {31'd0, char_valid}, 1);
        chk("fetch_code_t2", {24'd0, char_code}, 32'h41);
        step(); idle();

        // Host write collides with a video slot
        step(); cmd(1'b1, 12'd10, 8'h5A);
        step(); host_valid = 1'b0; slot(10'd8, 10'd0);
        @(negedge clk);
        chk("coll_vid_addr", {20'd0, ram_addr}, 1);
        chk("coll_vid_we", {31'd0, ram_we}, 0);
        step(); idle();
        @(negedge clk);
        chk("coll_wr_we", {31'd0, ram_we}, 1);
        chk("coll_wr_addr", {20'd0, ram_addr}, 10);
        chk("coll_wr_data", {24'd0, ram_wdata}, 32'h5A);
        step(); cmd(1'b0, 12'd10, 8'h00);
        step(); host_valid = 1'b0;
        @(negedge clk);
        chk("rd10_pop_addr", {20'd0, ram_addr}, 10);
        chk("rd10_pop_we", {31'd0, ram_we}, 0);
        step();
        @(negedge clk);
        chk("rd10_p1_rvalid", {31'd0, host_rvalid}, 0);
        step();
        @(negedge clk);
        chk("rd10_p2_rvalid", {31'd0, host_rvalid}, 1);
        chk("rd10_p2_rdata", {24'd0, host_rdata}, 32'h5A);

        // Out-of-range read and write
        step(); cmd(1'b0, 12'd2400, 8'h00);
        step(); host_valid = 1'b0;
        @(negedge clk);
        chk("oor_pop_we", {31'd0, ram_we}, 0);
        chk("oor_pop_addr_hold", {20'd0, ram_addr}, 10);
        step();
        @(negedge clk);
        chk("oor_p1_rvalid", {31'd0, host_rvalid}, 0);
        chk("oor_err_set", {31'd0, addr_err}, 1);
        step();
        @(negedge clk);
        chk("oor_p2_rvalid", {31'd0, host_rvalid}, 1);
        chk("oor_p2_rdata", {24'd0, host_rdata}, 0);
        step(); cmd(1'b1, 12'd4095, 8'hEE);
        step(); host_valid = 1'b0;
        @(negedge clk);
        chk("oor_wr_we", {31'd0, ram_we}, 0);
        repeat (3) step();
        @(negedge clk);
        chk("oor_err_sticky", {31'd0, addr_err}, 1);

        // Fill the FIFO behind back-to-back video slots, then drain
        step(); slot(10'd0, 10'd0); cmd(1'b1, 12'd20, 8'hA1);
        step(); cmd(1'b0, 12'd20, 8'h00);
        step(); cmd(1'b1, 12'd21, 8'hB2);
        step(); cmd(1'b0, 12'd21, 8'h00);
        step(); host_valid = 1'b0;
        @(negedge clk);
        chk("full_ready_low", {31'd0, host_ready}, 0);
        step();
        @(negedge clk);
        chk("full_ready_hold", {31'd0, host_ready}, 0);
        chk("full_vid_addr", {20'd0, ram_addr}, 0);
        step(); idle();
        @(negedge clk);
        chk("drain1_we", {31'd0, ram_we}, 1);
        chk("drain1_addr", {20'd0, ram_addr}, 20);
        chk("drain1_data", {24'd0, ram_wdata}, 32'hA1);
        step();
        @(negedge clk);
        chk("drain2_we", {31'd0, ram_we}, 0);
        chk("drain2_addr", {20'd0, ram_addr}, 20);
        chk("drain_ready", {31'd0, host_ready}, 1);
        step();
        @(negedge clk);
        chk("drain3_we", {31'd0, ram_we}, 1);
        chk("drain3_addr", {20'd0, ram_addr}, 21);
        chk("drain3_data", {24'd0, ram_wdata}, 32'hB2);
        step();
        @(negedge clk);
        chk("drain4_addr", {20'd0, ram_addr}, 21);
        chk("drain4_rvalid", {31'd0, host_rvalid}, 1);
        chk("drain4_rdata", {24'd0, host_rdata}, 32'hA1);
        step();
        @(negedge clk);
        chk("drain5_we", {31'd0, ram_we}, 0);
        step();
        @(negedge clk);
        chk("drain6_rvalid", {31'd0, host_rvalid}, 1);
        chk("drain6_rdata", {24'd0, host_rdata}, 32'hB2);

        // Reset with three reads still queued
        step(); slot(10'd0, 10'd16); cmd(1'b0, 12'd1, 8'h00);
        step(); cmd(1'b0, 12'd2, 8'h00);
        step(); cmd(1'b0, 12'd3, 8'h00);
        step(); host_valid = 1'b0;
        @(negedge clk);
        chk("queued3_ready", {31'd0, host_ready}, 1);
        step(); rst = 1'b1; idle();
        @(negedge clk);
        chk_reset_outputs();
        step(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("post_rst_no_rvalid", {31'd0, host_rvalid}, 0);
        end
        step(); cmd(1'b0, 12'd5, 8'h00);
        step(); host_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_pop_addr", {20'd0, ram_addr}, 5);
        step(); step();
        @(negedge clk);
        chk("post_rst_rvalid", {31'd0, host_rvalid}, 1);
        chk("post_rst_rdata", {24'd0, host_rdata}, {24'd0, shadow[5]});

        // Pixel-counter sweep across the bottom of the display into blanking
        x = 0; y = 470; ph = 1'b0;
        for (int n = 0; n < 20 * 1600; n++) begin
            step();
            p_tick = ph; pixel_x = 10'(x); pixel_y = 10'(y);
            video_on = (x < 640) && (y < 480);
            if ($urandom_range(0, 2) == 0) begin
                host_valid = 1'b1;
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = ($urandom_range(0, 19) == 0) ? 12'($urandom_range(2400, 4095))
                                                          : 12'($urandom_range(0, 2399));
                host_wdata = 8'($urandom);
            end else begin
                host_valid = 1'b0;
            end
            if (ph) begin
                x = x + 1;
                if (x == 800) begin
                    x = 0;
                    y = (y == 524) ? 0 : y + 1;
                end
            end
            ph = !ph;
        end
        step(); idle();
        repeat (30) step();
        @(negedge clk);
        chk("host_reads_drained", hq.size(), 0);
        chk("video_fetches_drained", vq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
